serial_to_parallel_rx: RTL and testbench

SERIAL_TO_PARALLEL_RX -- requirements
Module: serial_to_parallel_rx

---
 rtl/serial_to_parallel_rx.sv | 108 ++++++++++
 tb/tb_serial_to_parallel_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// Assembles WIDTH serial bits (MSB first) into a word; out_valid rises the cycle after the last bit edge.
// One-word holding register with valid/ready: a word completing while the register is still full is dropped and flags overrun.
module serial_to_parallel_rx #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             out_ready,
    input  logic             clear_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    output logic [7:0]       word_count
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-2:0] shift_q;

    logic             last_bit;
    logic             complete;
    logic             handshake;
    logic             load;
    logic             drop;
    logic             abort;
    logic [WIDTH-1:0] next_word;

    // The last bit goes straight from serial_in into the word, so only WIDTH-1 bits are ever stored.
    assign next_word = {shift_q, serial_in};
    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
    assign complete  = (state == SHIFT) && !start && bit_valid && last_bit;
    assign handshake = out_valid && out_ready;
    assign load      = complete && (!out_valid || handshake);
    assign drop      = complete && out_valid && !out_ready;
    assign abort     = (state == SHIFT) && start && (bit_cnt != '0);
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            word_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    // start wins over a coincident bit, even the one that would finish the word
                    if (start) begin
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end else if (bit_valid) begin
                        shift_q <= next_word[WIDTH-2:0];
                        if (last_bit) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase

            if (load) begin
                out_data   <= next_word;
                out_valid  <= 1'b1;
                word_count <= word_count + 8'd1;
            end else if (handshake) begin
                out_valid  <= 1'b0;
            end

            // Set events beat clear_err on the same edge.
            if (drop)
                overrun <= 1'b1;
            else if (clear_err)
                overrun <= 1'b0;

            if (abort)
                frame_err <= 1'b1;
            else if (clear_err)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx (WIDTH=6) with a queue of expected delivered words.
module tb_serial_to_parallel_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       serial_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_err = 1'b0;
    logic [5:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic       frame_err;
    logic [7:0] word_count;

    int         errors = 0;
    int         checks = 0;
    logic [5:0] exp_q[$];
    logic [7:0] exp_wc = 8'd0;
    logic [5:0] w;

    serial_to_parallel_rx #(.WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .out_ready  (out_ready),
        .clear_err  (clear_err),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // serial_in/bit_valid are driven high on the start edge to show they are ignored there.
    task automatic do_start();
        start     = 1'b1;
        bit_valid = 1'b1;
        serial_in = 1'b1;
        step();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [5:0] word, input bit gaps, input logic last_rdy, input logic last_clr);
        for (int i = 5; i >= 0; i--) begin
            serial_in = word[i];
            bit_valid = 1'b1;
            if (i == 0) begin
                out_ready = last_rdy;
                clear_err = last_clr;
            end
            step();
            clear_err = 1'b0;
            if (gaps && i > 0) begin
                bit_valid = 1'b0;
                serial_in = ~word[i];
                step();
                chk("gap_busy", busy, 1'b1);
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("accept_valid_clear", out_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_data", out_data, 6'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_wc", word_count, exp_wc);

        // bit_valid in IDLE is ignored
        bit_valid = 1'b1;
        serial_in = 1'b1;
        repeat (3) step();
        bit_valid = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", out_valid, 1'b0);

        // Basic word 2D with consecutive bits
        exp_q.push_back(6'h2D);
        exp_wc++;
        do_start();
        chk("start_busy", busy, 1'b1);
        send_bits(6'h2D, 1'b0, 1'b0, 1'b0);
        chk("w1_valid", out_valid, 1'b1);
        chk("w1_busy", busy, 1'b0);
        chk("w1_wc", word_count, exp_wc);
        chk("w1_data", out_data, exp_q.pop_front());
        accept();
        chk("hold_after_hs", out_data, 6'h2D);

        // Same word with gapped bit_valid
        exp_q.push_back(6'h2D);
        exp_wc++;
        do_start();
        send_bits(6'h2D, 1'b1, 1'b0, 1'b0);
        chk("w2_valid", out_valid, 1'b1);
        chk("w2_wc", word_count, exp_wc);
        chk("w2_data", out_data, exp_q.pop_front());
        accept();

        // Overrun: 2D held, 12 dropped; clear_err on the drop edge must lose
        exp_q.push_back(6'h2D);
        exp_wc++;
        do_start();
        send_bits(6'h2D, 1'b0, 1'b0, 1'b0);
        chk("w3_data", out_data, exp_q[0]);
        do_start();
        send_bits(6'h12, 1'b0, 1'b0, 1'b1);
        chk("ovr_data_kept", out_data, exp_q[0]);
        chk("ovr_valid", out_valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_wc", word_count, exp_wc);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Completion coinciding with a handshake loads the new word
        exp_q.push_back(6'h12);
        exp_wc++;
        do_start();
        send_bits(6'h12, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("hs_load_data", out_data, exp_q.pop_front());
        chk("hs_load_valid", out_valid, 1'b1);
        chk("hs_load_overrun", overrun, 1'b0);
        chk("hs_load_wc", word_count, exp_wc);
        accept();

        // Restart after 3 bits sets frame_err
        do_start();
        w = 6'b101000;
        for (int i = 5; i >= 3; i--) begin
            serial_in = w[i];
            bit_valid = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        do_start();
        chk("ferr_set", frame_err, 1'b1);
        chk("ferr_busy", busy, 1'b1);
        exp_q.push_back(6'h3F);
        exp_wc++;
        send_bits(6'h3F, 1'b0, 1'b0, 1'b0);
        chk("ferr_data", out_data, exp_q.pop_front());
        chk("ferr_wc", word_count, exp_wc);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("ferr_cleared", frame_err, 1'b0);
        accept();

        // start beats a would-be last bit
        do_start();
        w = 6'b111110;
        for (int i = 5; i >= 1; i--) begin
            serial_in = w[i];
            bit_valid = 1'b1;
            step();
        end
        start     = 1'b1;
        serial_in = 1'b0;
        bit_valid = 1'b1;
        step();
        start     = 1'b0;
        bit_valid = 1'b0;
        chk("prio_valid", out_valid, 1'b0);
        chk("prio_busy", busy, 1'b1);
        chk("prio_ferr", frame_err, 1'b1);
        chk("prio_wc", word_count, exp_wc);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;

        // Reset mid-word
        w = 6'b110100;
        for (int i = 5; i >= 2; i--) begin
            serial_in = w[i];
            bit_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_wc = 8'd0;
        chk("mrst_data", out_data, 6'h00);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ferr", frame_err, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);
        chk("mrst_wc", word_count, exp_wc);
        serial_in = 1'b1;
        bit_valid = 1'b1;
        repeat (8) step();
        bit_valid = 1'b0;
        chk("mrst_ignored_busy", busy, 1'b0);
        chk("mrst_ignored_valid", out_valid, 1'b0);

        // 257 back-to-back accepted words; word_count wraps to 1
        out_ready = 1'b1;
        for (int n = 0; n < 257; n++) begin
            w = 6'($urandom_range(0, 63));
            exp_q.push_back(w);
            exp_wc++;
            do_start();
            send_bits(w, 1'b0, 1'b1, 1'b0);
            chk("b2b_data", out_data, exp_q.pop_front());
        end
        chk("wrap_wc", word_count, exp_wc);
        chk("wrap_wc_is_1", word_count, 8'd1);
        chk("wrap_overrun", overrun, 1'b0);
        step();
        out_ready = 1'b0;
        chk("wrap_drained", out_valid, 1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
